// File: rtl/kcpsmx_call_stack.sv
// Call/return stack: circular buffer of {is_int, flags, return address} with sticky error flags.
// Top-of-stack outputs are combinational from registered state; push/pop take effect at the next edge.
module kcpsmx_call_stack #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 31,
   parameter int FLAG_BITS  = 2,
   parameter int OVF_MODE   = 0
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_push,
   input  logic [ADDR_WIDTH-1:0]      i_push_data,
   input  logic [FLAG_BITS-1:0]       i_push_flags,
   input  logic                       i_push_is_int,
   input  logic                       i_pop,
   input  logic                       i_pop_expect_int,
   input  logic                       i_err_clear,
   output logic [ADDR_WIDTH-1:0]      o_top_data,
   output logic [FLAG_BITS-1:0]       o_top_flags,
   output logic                       o_top_is_int,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overflow,
   output logic                       o_underflow,
   output logic                       o_frame_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
   logic [FLAG_BITS-1:0]  r_flags [DEPTH];
   logic                  r_int   [DEPTH];
   logic [IDX_W-1:0]      r_head;
   logic [LVL_W-1:0]      r_level;
   logic                  r_ovf, r_unf, r_fe;

   logic                  w_empty, w_full, w_pop_ok, w_pop_only, w_replace, w_push_adv;
   logic                  w_write, w_set_ovf, w_set_unf, w_set_fe;
   logic [IDX_W-1:0]      w_head_inc, w_head_dec, w_wr_idx, w_head_nxt;
   logic [LVL_W-1:0]      w_level_nxt;

   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == LVL_W'(DEPTH));
   // Indices wrap modulo DEPTH, which need not be a power of two.
   assign w_head_inc = (r_head == IDX_W'(DEPTH-1)) ? '0 : r_head + 1'b1;
   assign w_head_dec = (r_head == '0) ? IDX_W'(DEPTH-1) : r_head - 1'b1;

   // A pop on an empty stack is ignored, so push+pop then behaves as a plain push.
   assign w_pop_ok   = i_pop & ~w_empty;
   assign w_pop_only = w_pop_ok & ~i_push;
   assign w_replace  = i_push & w_pop_ok;
   assign w_push_adv = i_push & ~w_pop_ok & (~w_full | (OVF_MODE == 0));
   assign w_write    = w_replace | w_push_adv;
   assign w_wr_idx   = w_replace ? r_head : w_head_inc;

   assign w_set_ovf  = i_push & ~w_pop_ok & w_full;
   assign w_set_unf  = i_pop & w_empty;
   assign w_set_fe   = w_pop_ok & (i_pop_expect_int != r_int[r_head]);

   always_comb begin
      w_head_nxt  = r_head;
      w_level_nxt = r_level;
      if (w_push_adv) begin
         w_head_nxt = w_head_inc;
         if (!w_full) w_level_nxt = r_level + 1'b1;
      end else if (w_pop_only) begin
         w_head_nxt  = w_head_dec;
         w_level_nxt = r_level - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_head  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_head  <= w_head_nxt;
         r_level <= w_level_nxt;
         r_ovf   <= (r_ovf & ~i_err_clear) | w_set_ovf;
         r_unf   <= (r_unf & ~i_err_clear) | w_set_unf;
         r_fe    <= (r_fe  & ~i_err_clear) | w_set_fe;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset_n && w_write) begin
         r_addr[w_wr_idx]  <= i_push_data;
         r_flags[w_wr_idx] <= i_push_flags;
         r_int[w_wr_idx]   <= i_push_is_int;
      end
   end

   assign o_top_data   = w_empty ? '0   : r_addr[r_head];
   assign o_top_flags  = w_empty ? '0   : r_flags[r_head];
   assign o_top_is_int = w_empty ? 1'b0 : r_int[r_head];
   assign o_level      = r_level;
   assign o_empty      = w_empty;
   assign o_full       = w_full;
   assign o_overflow   = r_ovf;
   assign o_underflow  = r_unf;
   assign o_frame_err  = r_fe;

endmodule
